// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, hardwired-zero r0, and a pending-writer scoreboard.
// Optional write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write_en,
   input  logic [ADDR_W-1:0] reg_write_dest,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic [ADDR_W-1:0] reg_read_addr_1,
   output logic [DATA_W-1:0] reg_read_data_1,
   input  logic [ADDR_W-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0] reg_read_data_2,
   input  logic              sb_issue_en,
   input  logic [ADDR_W-1:0] sb_issue_dest,
   output logic              reg_pending_1,
   output logic              reg_pending_2,
   output logic              hazard_stall
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pending_q;
   logic [DEPTH-1:0]  pending_d;

   logic wr_vld;
   logic iss_vld;

   assign wr_vld  = reg_write_en && (reg_write_dest != '0);
   assign iss_vld = sb_issue_en && (sb_issue_dest != '0);

   // Issue is applied after writeback so a same-index issue keeps the register pending.
   always_comb begin
      mem_d     = mem_q;
      pending_d = pending_q;
      if (wr_vld) begin
         mem_d[reg_write_dest]     = reg_write_data;
         pending_d[reg_write_dest] = 1'b0;
      end
      if (iss_vld) begin
         pending_d[sb_issue_dest] = 1'b1;
      end
      if (rst) begin
         mem_d     = '{default: '0};
         pending_d = '0;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
   end

   logic [DATA_W-1:0] rd1_d, rd2_d;
   logic              pend1_d, pend2_d;

   always_comb begin
      rd1_d   = (reg_read_addr_1 == '0) ? '0 : mem_q[reg_read_addr_1];
      rd2_d   = (reg_read_addr_2 == '0) ? '0 : mem_q[reg_read_addr_2];
      pend1_d = pending_q[reg_read_addr_1];
      pend2_d = pending_q[reg_read_addr_2];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle writeback retires the hazard unless a new writer issues to the same register.
      if (wr_vld && (reg_read_addr_1 == reg_write_dest)) begin
         rd1_d = reg_write_data;
         if (!(sb_issue_en && (sb_issue_dest == reg_read_addr_1))) begin
            pend1_d = 1'b0;
         end
      end
      if (wr_vld && (reg_read_addr_2 == reg_write_dest)) begin
         rd2_d = reg_write_data;
         if (!(sb_issue_en && (sb_issue_dest == reg_read_addr_2))) begin
            pend2_d = 1'b0;
         end
      end
`endif
   end

   assign reg_read_data_1 = rd1_d;
   assign reg_read_data_2 = rd2_d;
   assign reg_pending_1   = pend1_d;
   assign reg_pending_2   = pend2_d;
   assign hazard_stall    = pend1_d | pend2_d;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default 16x8 instance plus a 32x16 instance).
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic        rst, we, iss;
   logic [2:0]  wdest, ra1, ra2, idest;
   logic [15:0] wdata, rd1, rd2;
   logic        p1, p2, stall;

   // Wide instance
   logic        b_rst, b_we, b_iss;
   logic [3:0]  b_wdest, b_ra1, b_ra2, b_idest;
   logic [31:0] b_wdata, b_rd1, b_rd2;
   logic        b_p1, b_p2, b_stall;

   int n_cmp = 0;
   int n_err = 0;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst),
      .reg_write_en(we), .reg_write_dest(wdest), .reg_write_data(wdata),
      .reg_read_addr_1(ra1), .reg_read_data_1(rd1),
      .reg_read_addr_2(ra2), .reg_read_data_2(rd2),
      .sb_issue_en(iss), .sb_issue_dest(idest),
      .reg_pending_1(p1), .reg_pending_2(p2), .hazard_stall(stall)
   );

   regfile_scoreboard #(.DATA_W(32), .DEPTH(16)) dut_w (
      .clk(clk), .rst(b_rst),
      .reg_write_en(b_we), .reg_write_dest(b_wdest), .reg_write_data(b_wdata),
      .reg_read_addr_1(b_ra1), .reg_read_data_1(b_rd1),
      .reg_read_addr_2(b_ra2), .reg_read_data_2(b_rd2),
      .sb_issue_en(b_iss), .sb_issue_dest(b_idest),
      .reg_pending_1(b_p1), .reg_pending_2(b_p2), .hazard_stall(b_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; iss = 1'b0; wdest = '0; wdata = '0; idest = '0; ra1 = '0; ra2 = '0;
      b_rst = 1'b1; b_we = 1'b0; b_iss = 1'b0; b_wdest = '0; b_wdata = '0; b_idest = '0;
      b_ra1 = '0; b_ra2 = '0;
      tick;
      rst = 1'b0; b_rst = 1'b0;

      // Reset state on every address
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); ra2 = 3'(7 - i);
         #1;
         check("rst_rd1", 32'(rd1), 32'h0);
         check("rst_rd2", 32'(rd2), 32'h0);
         check("rst_stall", 32'(stall), 32'h0);
      end
      check("rst_p1", 32'(p1), 32'h0);
      check("rst_p2", 32'(p2), 32'h0);

      // Write r3, observe same cycle (bypass only) then next cycle
      we = 1'b1; wdest = 3'd3; wdata = 16'hBEEF; ra1 = 3'd3; ra2 = 3'd0;
      #1;
      check("wr_r3_same", 32'(rd1), BYP ? 32'hBEEF : 32'h0);
      tick;
      we = 1'b0;
      #1;
      check("wr_r3_rd1", 32'(rd1), 32'hBEEF);
      check("wr_r3_rd2_r0", 32'(rd2), 32'h0);

      // Writes to r0 are discarded
      we = 1'b1; wdest = 3'd0; wdata = 16'h1234;
      tick;
      we = 1'b0; ra1 = 3'd0;
      #1;
      check("r0_rd", 32'(rd1), 32'h0);
      check("r0_pend", 32'(p1), 32'h0);

      // Issue r5, then writeback clears it
      iss = 1'b1; idest = 3'd5;
      tick;
      iss = 1'b0; ra1 = 3'd5; ra2 = 3'd3;
      #1;
      check("iss_r5_p1", 32'(p1), 32'h1);
      check("iss_r5_stall", 32'(stall), 32'h1);
      check("iss_r5_p2", 32'(p2), 32'h0);
      we = 1'b1; wdest = 3'd5; wdata = 16'h00AA;
      #1;
      check("wb_r5_same_p1", 32'(p1), BYP ? 32'h0 : 32'h1);
      check("wb_r5_same_rd", 32'(rd1), BYP ? 32'h00AA : 32'h0);
      tick;
      we = 1'b0;
      #1;
      check("wb_r5_p1", 32'(p1), 32'h0);
      check("wb_r5_stall", 32'(stall), 32'h0);
      check("wb_r5_rd", 32'(rd1), 32'h00AA);

      // Same edge issue+writeback r2: set wins, data written
      iss = 1'b1; idest = 3'd2; we = 1'b1; wdest = 3'd2; wdata = 16'h5555;
      tick;
      iss = 1'b0; we = 1'b0; ra1 = 3'd2;
      #1;
      check("setclr_r2_rd", 32'(rd1), 32'h5555);
      check("setclr_r2_p", 32'(p1), 32'h1);

      // Same edge issue r4, writeback r6 (r6 was never pending)
      iss = 1'b1; idest = 3'd4; we = 1'b1; wdest = 3'd6; wdata = 16'h6666;
      tick;
      iss = 1'b0; we = 1'b0; ra1 = 3'd4; ra2 = 3'd6;
      #1;
      check("diff_r4_p", 32'(p1), 32'h1);
      check("diff_r6_p", 32'(p2), 32'h0);
      check("diff_r6_rd", 32'(rd2), 32'h6666);
      check("diff_stall", 32'(stall), 32'h1);

      // Double issue to r7, one writeback clears
      iss = 1'b1; idest = 3'd7;
      tick;
      tick;
      iss = 1'b0; ra2 = 3'd7;
      #1;
      check("dbl_r7_p", 32'(p2), 32'h1);
      we = 1'b1; wdest = 3'd7; wdata = 16'h0707;
      tick;
      we = 1'b0;
      #1;
      check("dbl_r7_clr", 32'(p2), 32'h0);
      check("dbl_r7_rd", 32'(rd2), 32'h0707);

      // r1 = 0x0011 and pending, then reset with concurrent write
      iss = 1'b1; idest = 3'd1; we = 1'b1; wdest = 3'd1; wdata = 16'h0011;
      tick;
      iss = 1'b0; we = 1'b0; ra1 = 3'd1; ra2 = 3'd4;
      #1;
      check("pre_rst_r1_rd", 32'(rd1), 32'h0011);
      check("pre_rst_r1_p", 32'(p1), 32'h1);
      rst = 1'b1; we = 1'b1; wdest = 3'd1; wdata = 16'h7777; iss = 1'b1; idest = 3'd3;
      tick;
      rst = 1'b0; we = 1'b0; iss = 1'b0;
      #1;
      check("rst_r1_rd", 32'(rd1), 32'h0);
      check("rst_r1_p", 32'(p1), 32'h0);
      check("rst_r4_p", 32'(p2), 32'h0);
      ra2 = 3'd3;
      #1;
      check("rst_r3_rd", 32'(rd2), 32'h0);
      check("rst_r3_p", 32'(p2), 32'h0);

      // Writeback after reset still writes data, pending stays clear
      we = 1'b1; wdest = 3'd4; wdata = 16'h4444;
      tick;
      we = 1'b0; ra1 = 3'd4;
      #1;
      check("post_rst_r4_rd", 32'(rd1), 32'h4444);
      check("post_rst_r4_p", 32'(p1), 32'h0);

      // Wide instance: r15 write and scoreboard at the top index
      b_we = 1'b1; b_wdest = 4'd15; b_wdata = 32'hDEADBEEF;
      tick;
      b_we = 1'b0; b_ra1 = 4'd15; b_ra2 = 4'd0;
      #1;
      check("w_r15_rd", b_rd1, 32'hDEADBEEF);
      check("w_r0_rd", b_rd2, 32'h0);
      b_iss = 1'b1; b_idest = 4'd15;
      tick;
      b_iss = 1'b0;
      #1;
      check("w_r15_p", 32'(b_p1), 32'h1);
      check("w_stall", 32'(b_stall), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the pipelined successor of the 16-bit single-cycle MIPS core. It provides two combinational read ports, one write port, a hardwired-zero register 0, and a per-register pending scoreboard. The scoreboard marks destinations of in-flight instructions so the decode stage can stall on RAW hazards. It sits between decode (read/issue) and writeback (write/clear).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers; power of two, ≥2
- ADDR_W, $clog2(DEPTH), register address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk
- reg_write_en  in  1  writeback strobe
- reg_write_dest  in  ADDR_W  writeback register index
- reg_write_data  in  DATA_W  writeback data
- reg_read_addr_1  in  ADDR_W  read port 1 index
- reg_read_data_1  out  DATA_W  read port 1 data
- reg_read_addr_2  in  ADDR_W  read port 2 index
- reg_read_data_2  out  DATA_W  read port 2 data
- sb_issue_en  in  1  issue strobe: mark sb_issue_dest pending
- sb_issue_dest  in  ADDR_W  destination of issuing instruction
- reg_pending_1  out  1  register at reg_read_addr_1 is pending
- reg_pending_2  out  1  register at reg_read_addr_2 is pending
- hazard_stall  out  1  reg_pending_1 | reg_pending_2

## Operation
- Storage: DEPTH×DATA_W array plus DEPTH-bit pending vector.
- Write: on rising edge with reg_write_en=1 and reg_write_dest≠0, array[dest] ← reg_write_data. Writes to index 0 are discarded.
- Read: combinational. An address of 0 returns 0; any other address returns array[addr].
- Scoreboard set: on an edge with sb_issue_en=1 and sb_issue_dest≠0, pending[dest] ← 1.
- Scoreboard clear: on an edge with reg_write_en=1 and reg_write_dest≠0, pending[dest] ← 0.
- Simultaneous set and clear of the same index: set wins, because the newly issued instruction owns the register. Data is still written.
- Set and clear of different indices in the same cycle: both take effect.
- Issue to an already-pending register: stays pending (no counting; the pipeline holds at most one in-flight writer per register).
- Writeback to a non-pending register: data written; pending stays 0.
- pending[0] is constant 0. reg_pending_n = pending[reg_read_addr_n], combinational.
- Out-of-range indices cannot occur (DEPTH = 2^ADDR_W).

## Timing
- Reset: on an edge with rst=1, all array entries ← 0 and pending ← 0. Reset overrides same-cycle write and issue.
- After reset: reg_read_data_1/2 = 0 and reg_pending_1/2 = 0, hazard_stall = 0.
- Read latency 0 cycles from address to data. Write visible to reads in the cycle after the edge, unless bypass is compiled in.
- Pending set visible the cycle after the issue edge. Pending clear visible the cycle after the writeback edge, unless bypass is compiled in.
- Reset asserted mid-operation drops all pending bits. In-flight writebacks after reset still write data normally.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If reg_write_en=1, reg_write_dest≠0 and reg_read_addr_n==reg_write_dest, then reg_read_data_n = reg_write_data in the same cycle.
  - In that case reg_pending_n is forced to 0, unless sb_issue_en=1 with sb_issue_dest equal to that address.
  - This removes the one-cycle writeback stall.
- Undefined: reads return only the stored array and stored pending bits; the same-cycle writeback is seen one cycle later.

## Test plan
- Reset, then read all addresses → every read returns 0x0000; reg_pending_1/2=0; hazard_stall=0.
- Write 0xBEEF to r3, then read r3 on port 1 and r0 on port 2 next cycle → 0xBEEF and 0x0000. Write 0x1234 to r0 → r0 still reads 0.
- Issue r5 → next cycle reading r5 gives reg_pending_1=1 and hazard_stall=1. Writeback 0x00AA to r5 → pending clears (same cycle with REGFILE_BYPASS_EN, next cycle without) and the read returns 0x00AA.
- Same edge: issue r2 and writeback r2 with 0x5555 → r2 reads 0x5555 and remains pending.
- Same edge: issue r4 and writeback r6 → r4 pending and r6 not pending. With DATA_W=32, DEPTH=16, write 0xDEADBEEF to r15 → reads back intact.
- With r1=0x0011 and r1 pending, assert rst with a concurrent write of 0x7777 to r1 → r1=0 and not pending after the edge.
